cpu_uart_receiver: RTL and testbench

UART 8N1 receiver for the single-cycle CPU's serial peripheral. It consumes the baud-rate generator's `sampleclk` square wave, which runs at OVERSAMPLE × 9600 Hz, and turns its rising edges into sample ticks inside the `sysclk` domain. It deserialises the `uart_rx` line and presents each byte through a one-entry valid/ready buffer to the CPU's peripheral bus logic.

---
 rtl/cpu_uart_pkg.sv | 7 +
 rtl/cpu_uart_rx_sync.sv | 22 ++
 rtl/cpu_uart_receiver.sv | 95 +++++++++
 tb/tb_cpu_uart_receiver.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cpu_uart_pkg.sv
// cpu_uart_pkg: shared FSM states and default parameters for the UART receiver
package cpu_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int OVERSAMPLE_DEF = 64;
  localparam int DATA_BITS_DEF = 8;
  localparam int TICK_CYCLES = 162;
endpackage

// File: rtl/cpu_uart_rx_sync.sv
// cpu_uart_rx_sync: uart_rx 2-FF synchroniser and sampleclk rising-edge tick
module cpu_uart_rx_sync (
  input  logic sysclk,
  input  logic reset,
  input  logic sampleclk,
  input  logic uart_rx,
  output logic rx_s,
  output logic tick
);
  logic [1:0] sync;
  logic sclk_q;
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) begin
      sync <= '1;
      sclk_q <= 1'b1;
    end else begin
      sync <= {sync[0], uart_rx};
      sclk_q <= sampleclk;
    end
  assign rx_s = sync[1];
  assign tick = sampleclk & ~sclk_q;
endmodule

// File: rtl/cpu_uart_receiver.sv
// cpu_uart_receiver: oversampled 8N1 UART receiver with one-entry valid/ready output buffer
module cpu_uart_receiver
  import cpu_uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 sampleclk,
  input  logic                 uart_rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic rx_s, tick, load, ferr;
  cpu_uart_rx_sync u_sync (
    .sysclk(sysclk),
    .reset(reset),
    .sampleclk(sampleclk),
    .uart_rx(uart_rx),
    .rx_s(rx_s),
    .tick(tick)
  );
  // START compares one below the midpoint so its verify lands on tick OVERSAMPLE/2-1
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bit_n = bit_idx;
    shift_n = shift;
    load = 1'b0;
    ferr = 1'b0;
    if (tick)
      case (state)
        IDLE:
          if (!rx_s) begin
            state_n = START;
            cnt_n = '0;
          end
        START:
          if (cnt == CW'(OVERSAMPLE / 2 - 2)) begin
            state_n = rx_s ? IDLE : DATA;
            cnt_n = '0;
            bit_n = '0;
          end else cnt_n = cnt + 1'b1;
        DATA:
          if (cnt == CW'(OVERSAMPLE - 1)) begin
            shift_n = {rx_s, shift[DATA_BITS-1:1]};
            cnt_n = '0;
            bit_n = bit_idx + 1'b1;
            state_n = (bit_idx == BW'(DATA_BITS - 1)) ? STOP : DATA;
          end else cnt_n = cnt + 1'b1;
        default:
          if (cnt == CW'(OVERSAMPLE - 1)) begin
            load = rx_s;
            ferr = ~rx_s;
            state_n = IDLE;
            cnt_n = '0;
          end else cnt_n = cnt + 1'b1;
      endcase
  end
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      shift <= shift_n;
    end
  // a load always wins; overrun only when the old byte was neither consumed nor replaced by a handshake
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_data <= load ? shift : rx_data;
      rx_valid <= load | (rx_valid & ~rx_ready);
      rx_frame_err <= ferr;
      rx_overrun <= load & rx_valid & ~rx_ready;
    end
endmodule

// File: tb/tb_cpu_uart_receiver.sv
// tb_cpu_uart_receiver: scoreboard bench for cpu_uart_receiver at a reduced oversample rate
module tb_cpu_uart_receiver;
  import cpu_uart_pkg::*;
  localparam int OS = 16;
  localparam int BIT = OS * 4;
  localparam int FRAME = 10 * BIT;
  logic sysclk = 1'b0, reset = 1'b0, sampleclk = 1'b1, uart_rx = 1'b1, rx_ready = 1'b1;
  logic sclk_run = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, rx_frame_err, rx_overrun;
  int n_chk = 0, n_pass = 0;
  int valid_cycles = 0, ferr_cycles = 0, ovr_cycles = 0, nb = 0;
  logic pv = 1'b0;
  logic [7:0] exp_q[$];
  int v0, f0, o0, b0;
  logic [31:0] snap;

  cpu_uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .sysclk(sysclk),
    .reset(reset),
    .sampleclk(sampleclk),
    .uart_rx(uart_rx),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_overrun(rx_overrun)
  );

  always #5 sysclk = ~sysclk;

  // sampleclk period is 4 sysclk cycles; a stall parks it high
  initial forever begin
    repeat (2) @(negedge sysclk);
    sampleclk = sclk_run ? ~sampleclk : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // a new byte appears when valid rises, follows an accept, or overwrites with overrun
  always @(posedge sysclk) begin
    #1;
    if (rx_valid && (!pv || rx_ready || rx_overrun)) begin
      nb++;
      if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 1);
      else check("data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    valid_cycles += int'(rx_valid);
    ferr_cycles += int'(rx_frame_err);
    ovr_cycles += int'(rx_overrun);
    pv = rx_valid;
  end

  task automatic send(input logic [7:0] b, input logic stop, input int from, input int to);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = from; i < to; i++) begin
      @(negedge sysclk);
      if (i / BIT >= 10) uart_rx = 1'b1;
      else if (i / BIT == 9 && i % BIT >= 3 * BIT / 4) uart_rx = 1'b1;
      else uart_rx = f[i / BIT];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  initial begin
    idle(3);
    check("rst_data", 32'(rx_data), 0);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_ferr", 32'(rx_frame_err), 0);
    check("rst_ovr", 32'(rx_overrun), 0);
    reset = 1'b1;
    idle(2 * BIT);
    // back-to-back frames, consumer always ready
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1, 0, FRAME);
    exp_q.push_back(8'hA3);
    send(8'hA3, 1'b1, 0, FRAME);
    idle(2 * BIT);
    check("b2b_bytes", 32'(nb), 2);
    check("b2b_valid_cycles", 32'(valid_cycles), 2);
    check("b2b_ferr", 32'(ferr_cycles), 0);
    check("b2b_ovr", 32'(ovr_cycles), 0);
    // short low glitch
    v0 = valid_cycles; f0 = ferr_cycles;
    uart_rx = 1'b0;
    idle(12);
    uart_rx = 1'b1;
    idle(2 * BIT);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    check("glitch_valid", 32'(valid_cycles - v0), 0);
    check("glitch_ferr", 32'(ferr_cycles - f0), 0);
    // bad stop bit then a good frame
    v0 = valid_cycles; f0 = ferr_cycles;
    send(8'h3C, 1'b0, 0, FRAME);
    idle(2 * BIT);
    check("ferr_pulse", 32'(ferr_cycles - f0), 1);
    check("ferr_no_valid", 32'(valid_cycles - v0), 0);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1, 0, FRAME);
    idle(2 * BIT);
    check("after_ferr_queue", 32'(exp_q.size()), 0);
    // overrun with consumer stalled
    rx_ready = 1'b0;
    o0 = ovr_cycles;
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1, 0, FRAME);
    idle(BIT);
    check("hold_valid", 32'(rx_valid), 1);
    check("hold_data", 32'(rx_data), 32'h12);
    exp_q.push_back(8'h34);
    send(8'h34, 1'b1, 0, FRAME);
    idle(BIT);
    check("ovr_pulse", 32'(ovr_cycles - o0), 1);
    check("ovr_data", 32'(rx_data), 32'h34);
    check("ovr_valid", 32'(rx_valid), 1);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    idle(1);
    check("accept_clears", 32'(rx_valid), 0);
    rx_ready = 1'b1;
    idle(BIT);
    // async reset mid data bit 4
    b0 = nb;
    send(8'hF0, 1'b1, 0, 5 * BIT + BIT / 2);
    reset = 1'b0;
    #1;
    check("mid_rst_data", 32'(rx_data), 0);
    check("mid_rst_valid", 32'(rx_valid), 0);
    check("mid_rst_ferr", 32'(rx_frame_err), 0);
    check("mid_rst_ovr", 32'(rx_overrun), 0);
    uart_rx = 1'b1;
    idle(5);
    reset = 1'b1;
    idle(2 * BIT);
    exp_q.push_back(8'h0F);
    send(8'h0F, 1'b1, 0, FRAME);
    idle(2 * BIT);
    check("post_rst_one_byte", 32'(nb - b0), 1);
    // sampleclk stall mid-frame
    exp_q.push_back(8'hC5);
    send(8'hC5, 1'b1, 0, 4 * BIT + BIT / 2);
    sclk_run = 1'b0;
    idle(10);
    snap = 32'({dut.state, dut.cnt, dut.bit_idx, dut.shift});
    idle(1000);
    check("stall_hold", 32'({dut.state, dut.cnt, dut.bit_idx, dut.shift}), snap);
    check("stall_state", 32'(dut.state), 32'(DATA));
    sclk_run = 1'b1;
    send(8'hC5, 1'b1, 4 * BIT + BIT / 2, FRAME);
    idle(2 * BIT);
    check("final_queue_empty", 32'(exp_q.size()), 0);
    check("final_ferr_total", 32'(ferr_cycles), 1);
    check("final_ovr_total", 32'(ovr_cycles), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
